// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Contents: width localparams, opcode encodings, FSM state encoding,
// request payload struct and the opcode legality helper.
package alu_arbiter_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned LAT_W = 4;

  localparam logic [OP_W-1:0] AND_OP = 3'b000;
  localparam logic [OP_W-1:0] OR_OP  = 3'b001;
  localparam logic [OP_W-1:0] ADD_OP = 3'b010;
  localparam logic [OP_W-1:0] SUB_OP = 3'b011;
  localparam logic [OP_W-1:0] SLT_OP = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Operation payload carried by one request.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  // Opcodes above SLT have no ALU meaning and are answered with an error.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= SLT_OP;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals of the arbiter.
// slave  : arbiter view (requests/ALU results in, readies/responses/ALU operands out)
// master : environment view (requesters, response consumers and the ALU)
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [OP_W-1:0]  req0_op,    req1_op;
  logic [WIDTH-1:0] req0_a,     req1_a;
  logic [WIDTH-1:0] req0_b,     req1_b;

  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_overflow, rsp_zero, rsp_err;

  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow, alu_zero;

  logic             busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result, alu_overflow, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_overflow, rsp_zero, rsp_err,
    output alu_op, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
    output rsp0_ready, rsp1_ready, alu_result, alu_overflow, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_overflow, rsp_zero, rsp_err,
    input  alu_op, alu_a, alu_b, busy
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin arbiter.
// Ports: valid_i (per-port request), last_grant_i (port served last),
//        grant_c (one-hot grant, zero when nobody requests).
module alu_arbiter_rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_c
);

  // A lone requester wins; on a tie the port not served last wins.
  always_comb begin
    grant_c = valid_i;
    if (&valid_i) begin
      grant_c = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters with round-robin arbitration.
// Ports: clk, rst (async, active-high), bus (alu_arbiter_if.slave) carrying
//        both request handshakes, both response handshakes with shared
//        response data/flags, the ALU operand/result lines and busy.
// Parameter ALU_LAT: cycles the operands are held on the ALU before sampling.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_overflow_q, rsp_overflow_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             busy_q, busy_d;

  logic [1:0]       grant_c;
  req_t             req_sel_c;
  logic             rsp_ready_sel_c;
  logic             req0_ready_c, req1_ready_c;

  alu_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .valid_i      ({bus.req1_valid, bus.req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_c      (grant_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    last_grant_d   = last_grant_q;
    grant_id_d     = grant_id_q;
    alu_op_d       = alu_op_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_err_d      = rsp_err_q;
    rsp0_valid_d   = rsp0_valid_q;
    rsp1_valid_d   = rsp1_valid_q;
    req0_ready_c   = 1'b0;
    req1_ready_c   = 1'b0;

    req_sel_c.op   = grant_c[1] ? bus.req1_op : bus.req0_op;
    req_sel_c.a    = grant_c[1] ? bus.req1_a  : bus.req0_a;
    req_sel_c.b    = grant_c[1] ? bus.req1_b  : bus.req0_b;
    rsp_ready_sel_c = grant_id_q ? bus.rsp1_ready : bus.rsp0_ready;

    case (state_q)
      IDLE: begin
        req0_ready_c = grant_c[0];
        req1_ready_c = grant_c[1];
        if (|grant_c) begin
          grant_id_d = grant_c[1];
          if (op_legal(req_sel_c.op)) begin
            // The ALU operand registers double as the latched request.
            alu_op_d  = req_sel_c.op;
            alu_a_d   = req_sel_c.a;
            alu_b_d   = req_sel_c.b;
            lat_cnt_d = '0;
            state_d   = EXEC;
          end else begin
            rsp_result_d   = '0;
            rsp_overflow_d = 1'b0;
            rsp_zero_d     = 1'b1;
            rsp_err_d      = 1'b1;
            rsp0_valid_d   = ~grant_c[1];
            rsp1_valid_d   = grant_c[1];
            state_d        = RESP;
          end
        end
      end
      EXEC: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          rsp_result_d   = bus.alu_result;
          rsp_overflow_d = bus.alu_overflow;
          rsp_zero_d     = bus.alu_zero;
          rsp_err_d      = 1'b0;
          rsp0_valid_d   = ~grant_id_q;
          rsp1_valid_d   = grant_id_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_sel_c) begin
          last_grant_d = grant_id_q;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; an in-flight operation is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      lat_cnt_q      <= '0;
      last_grant_q   <= 1'b1;
      grant_id_q     <= 1'b0;
      alu_op_q       <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lat_cnt_q      <= lat_cnt_d;
      last_grant_q   <= last_grant_d;
      grant_id_q     <= grant_id_d;
      alu_op_q       <= alu_op_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_err_q      <= rsp_err_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp1_valid_q   <= rsp1_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.req0_ready   = req0_ready_c;
  assign bus.req1_ready   = req1_ready_c;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.busy         = busy_q;

endmodule
